tmr_vote_controller: RTL and testbench

- Sequences the bitwise 3-input majority function across three redundant WIDTH-bit channels (A, B, C) using valid/ready handshakes.
- Each accepted sample is voted, and each channel is checked against the voted result.
- Per-channel consecutive-mismatch counters drive sticky fault flags.
- Sits between a triplicated datapath and its single downstream consumer, as the TMR voting/health-monitor stage.

---
 rtl/tmr_vote_controller.sv | 152 +++++++++++++++
 tb/tb_tmr_vote_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_vote_controller.sv
// TMR voting / health-monitor stage.
// Captures one triplicated sample per handshake, votes it bitwise, flags the
// channels that disagree with the vote, and tracks consecutive mismatches per
// channel. A channel whose streak reaches FAULT_THRESH gets a sticky fault flag.
module tmr_vote_controller #(
  parameter int WIDTH        = 8,
  parameter int ERR_CNT_W    = 4,
  parameter int FAULT_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     C,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic [2:0]           mismatch,
  output logic                 no_majority,
  output logic [2:0]           fault,
  output logic [ERR_CNT_W-1:0] err_cnt_a,
  output logic [ERR_CNT_W-1:0] err_cnt_b,
  output logic [ERR_CNT_W-1:0] err_cnt_c,
  input  logic                 clear_faults
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VOTE = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] THRESH  = ERR_CNT_W'(FAULT_THRESH);
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  state_t               state_q;
  state_t               state_d;
  logic                 capture_en;
  logic                 vote_en;

  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     c_q;

  logic [WIDTH-1:0]     voted;
  logic [2:0]           mismatch_next;

  logic [ERR_CNT_W-1:0] cnt_q [3];
  logic [ERR_CNT_W-1:0] cnt_d [3];
  logic [2:0]           fault_d;

  // State register; reset drops out_valid at once because it is decoded from state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode for the IDLE -> VOTE -> OUT sequence.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    capture_en = 1'b0;
    vote_en    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture_en = 1'b1;
          state_d    = VOTE;
        end
      end
      VOTE: begin
        vote_en = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample capture; only loaded on an accepted IDLE handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain registers rather than a memory array, so clearing
    // them on reset is cheap and keeps stale data out of the vote.
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else if (capture_en) begin
      a_q <= A;
      b_q <= B;
      c_q <= C;
    end
  end

  assign voted         = (a_q & b_q) | (a_q & c_q) | (b_q & c_q);
  assign mismatch_next = {c_q != voted, b_q != voted, a_q != voted};

  // Registered vote outputs; held stable through OUT until the next VOTE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      mismatch    <= '0;
      no_majority <= 1'b0;
    end else if (vote_en) begin
      result      <= voted;
      mismatch    <= mismatch_next;
      no_majority <= &mismatch_next;
    end
  end

  // Streak counters: a mismatch extends the streak (saturating), a match ends it.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = '0;
      if (mismatch_next[k]) begin
        cnt_d[k] = (cnt_q[k] == CNT_MAX) ? CNT_MAX : cnt_q[k] + CNT_ONE;
      end
      fault_d[k] = fault[k] | (cnt_d[k] >= THRESH);
    end
  end

  // Health state; clear_faults takes priority over a coincident vote update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= '0;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
    end else if (clear_faults) begin
      fault <= '0;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
    end else if (vote_en) begin
      fault <= fault_d;
      for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign err_cnt_a = cnt_q[0];
  assign err_cnt_b = cnt_q[1];
  assign err_cnt_c = cnt_q[2];

endmodule

// File: tb/tb_tmr_vote_controller.sv
// Self-checking bench for tmr_vote_controller: a transaction-level model is
// compared against the DUT on every falling edge, and directed scenarios pin
// the model with hand-computed literal values before a randomized phase.
module tb_tmr_vote_controller;

  localparam int WIDTH        = 8;
  localparam int ERR_CNT_W    = 4;
  localparam int FAULT_THRESH = 3;
  localparam int SAT          = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A, B, C;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic [2:0]           mismatch;
  logic                 no_majority;
  logic [2:0]           fault;
  logic [ERR_CNT_W-1:0] err_cnt_a, err_cnt_b, err_cnt_c;
  logic                 clear_faults;

  int checks = 0;
  int errors = 0;

  tmr_vote_controller #(
    .WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W), .FAULT_THRESH(FAULT_THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .mismatch(mismatch), .no_majority(no_majority),
    .fault(fault),
    .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c),
    .clear_faults(clear_faults)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Majority by counting ones per bit position.
  function automatic logic [WIDTH-1:0] maj(input logic [WIDTH-1:0] a, b, c);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  function automatic int next_cnt(input int cur, input logic mis);
    if (!mis) return 0;
    return (cur >= SAT) ? SAT : cur + 1;
  endfunction

  int               m_phase;   // 0 waiting for sample, 1 voting, 2 presenting
  logic [WIDTH-1:0] m_ch [3];
  logic [WIDTH-1:0] m_result;
  logic [2:0]       m_mis;
  logic             m_nomaj;
  logic [2:0]       m_fault;
  int               m_cnt [3];
  logic [WIDTH-1:0] m_vote_now;
  logic [2:0]       m_mis_now;

  always_comb begin
    m_vote_now = maj(m_ch[0], m_ch[1], m_ch[2]);
    for (int k = 0; k < 3; k++) m_mis_now[k] = (m_ch[k] != m_vote_now);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_result <= '0;
      m_mis    <= '0;
      m_nomaj  <= 1'b0;
      m_fault  <= '0;
      for (int k = 0; k < 3; k++) begin
        m_cnt[k] <= 0;
        m_ch[k]  <= '0;
      end
    end else begin
      if (clear_faults) begin
        m_fault <= '0;
        for (int k = 0; k < 3; k++) m_cnt[k] <= 0;
      end
      case (m_phase)
        0: if (in_valid) begin
          m_ch[0] <= A;
          m_ch[1] <= B;
          m_ch[2] <= C;
          m_phase <= 1;
        end
        1: begin
          m_result <= m_vote_now;
          m_mis    <= m_mis_now;
          m_nomaj  <= (m_mis_now == 3'b111);
          if (!clear_faults) begin
            for (int k = 0; k < 3; k++) begin
              m_cnt[k]   <= next_cnt(m_cnt[k], m_mis_now[k]);
              m_fault[k] <= m_fault[k] | (next_cnt(m_cnt[k], m_mis_now[k]) >= FAULT_THRESH);
            end
          end
          m_phase <= 2;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Compare process: handshake and health every cycle, vote data while presented.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_in_ready",  in_ready,  m_phase == 0);
      check("cmp_out_valid", out_valid, m_phase == 2);
      check("cmp_fault",     fault,     m_fault);
      check("cmp_err_cnt_a", err_cnt_a, m_cnt[0]);
      check("cmp_err_cnt_b", err_cnt_b, m_cnt[1]);
      check("cmp_err_cnt_c", err_cnt_c, m_cnt[2]);
      if (m_phase == 2) begin
        check("cmp_result",      result,      m_result);
        check("cmp_mismatch",    mismatch,    m_mis);
        check("cmp_no_majority", no_majority, m_nomaj);
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Called at posedge+1 while idle; returns at posedge+1 of the first OUT cycle.
  task automatic accept(input logic [WIDTH-1:0] a, b, c);
    A = a; B = b; C = c; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    check("lat_edge1_out_valid", out_valid, 1'b0);
    check("lat_edge1_in_ready",  in_ready,  1'b0);
    @(posedge clk); #1;
    check("lat_edge2_out_valid", out_valid, 1'b1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check("rel_in_ready",  in_ready,  1'b1);
    check("rel_out_valid", out_valid, 1'b0);
  endtask

  logic [WIDTH-1:0] held;
  int               bad;
  logic [WIDTH-1:0] base;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear_faults = 1'b0;
    A = '0; B = '0; C = '0;
    #2;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result",    result,    '0);
    check("rst_fault",     fault,     '0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Agreement.
    accept(8'h5A, 8'h5A, 8'h5A);
    check("agree_result",   result,      8'h5A);
    check("agree_mismatch", mismatch,    3'b000);
    check("agree_nomaj",    no_majority, 1'b0);
    release_out();

    // Single-channel error.
    accept(8'hFF, 8'h0F, 8'h0F);
    check("single_result",   result,    8'h0F);
    check("single_mismatch", mismatch,  3'b001);
    check("single_cnt_a",    err_cnt_a, 1);
    check("single_fault",    fault,     3'b000);
    release_out();

    // Persistence on channel B.
    for (int n = 1; n <= 3; n++) begin
      accept(8'h33, 8'h00, 8'h33);
      check("pers_result",   result,    8'h33);
      check("pers_mismatch", mismatch,  3'b010);
      check("pers_cnt_b",    err_cnt_b, n);
      check("pers_cnt_a",    err_cnt_a, 0);
      check("pers_fault",    fault,     (n == 3) ? 3'b010 : 3'b000);
      release_out();
    end
    accept(8'h33, 8'h33, 8'h33);
    check("clean_cnt_b", err_cnt_b, 0);
    check("clean_fault", fault,     3'b010);
    release_out();
    clear_faults = 1'b1;
    @(posedge clk); #1 clear_faults = 1'b0;
    check("clear_fault", fault, 3'b000);

    // No majority plus backpressure.
    accept(8'h01, 8'h02, 8'h04);
    check("nomaj_result",   result,      8'h00);
    check("nomaj_mismatch", mismatch,    3'b111);
    check("nomaj_flag",     no_majority, 1'b1);
    check("nomaj_cnt_a",    err_cnt_a,   1);
    check("nomaj_cnt_b",    err_cnt_b,   1);
    check("nomaj_cnt_c",    err_cnt_c,   1);
    held = result;
    for (int n = 0; n < 4; n++) begin
      A = 8'hEE; B = 8'hEE; C = 8'hEE;
      in_valid = n[0];
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready",  in_ready,  1'b0);
      check("bp_result",    result,    8'h00);
    end
    in_valid = 1'b0;
    release_out();

    // Saturation and clear coinciding with a vote edge.
    for (int n = 0; n < SAT + 2; n++) begin
      accept(8'hAA, 8'h55, 8'h55);
      release_out();
    end
    check("sat_cnt_a", err_cnt_a, SAT);
    check("sat_fault", fault,     3'b001);
    A = 8'hAA; B = 8'h55; C = 8'h55; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; clear_faults = 1'b1;
    @(posedge clk); #1 clear_faults = 1'b0;
    check("clrvote_cnt_a",    err_cnt_a, 0);
    check("clrvote_fault",    fault,     3'b000);
    check("clrvote_mismatch", mismatch,  3'b001);
    release_out();

    // Reset in the middle of OUT with nonzero health state.
    accept(8'h0F, 8'hF0, 8'hFF);
    check("pre_rst_cnt_a", err_cnt_a, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready",  in_ready,  1'b1);
    check("midrst_fault",     fault,     3'b000);
    check("midrst_cnt_a",     err_cnt_a, 0);
    check("midrst_cnt_b",     err_cnt_b, 0);
    check("midrst_cnt_c",     err_cnt_c, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    accept(8'hC3, 8'hC3, 8'h3C);
    check("post_rst_result",   result,   8'hC3);
    check("post_rst_mismatch", mismatch, 3'b100);
    release_out();

    // Randomized phase: one channel is persistently bad per block.
    for (int blk = 0; blk < 8; blk++) begin
      bad = $urandom_range(0, 3);  // 3 means no persistently bad channel
      for (int cyc = 0; cyc < 60; cyc++) begin
        base = WIDTH'($urandom);
        A = base; B = base; C = base;
        if (bad == 0 || $urandom_range(0, 7) == 0) A = base ^ WIDTH'($urandom_range(1, 255));
        if (bad == 1 || $urandom_range(0, 7) == 0) B = base ^ WIDTH'($urandom_range(1, 255));
        if (bad == 2 || $urandom_range(0, 7) == 0) C = base ^ WIDTH'($urandom_range(1, 255));
        in_valid     = ($urandom_range(0, 3) != 0);
        out_ready    = ($urandom_range(0, 3) != 0);
        clear_faults = ($urandom_range(0, 31) == 0);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; clear_faults = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
